// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
// Optional feature macro used by the design: DATA_MEM_ARB_ROUND_ROBIN_EN.
package data_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  localparam int PORT_CPU = 0;
  localparam int PORT_LDR = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_e;

endpackage

// File: rtl/data_mem_arbiter_arb_pick2.sv
// Two-requester winner selection producing a one-hot grant.
// On a tie the port that did not win last time is chosen.
module arb_pick2
  import data_mem_arbiter_pkg::*;
(
  input  logic       req_cpu_i,
  input  logic       req_ldr_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req_cpu_i && req_ldr_i) begin
      if (last_i == 1'(PORT_LDR)) begin
        gnt_o[PORT_CPU] = 1'b1;
      end else begin
        gnt_o[PORT_LDR] = 1'b1;
      end
    end else if (req_cpu_i) begin
      gnt_o[PORT_CPU] = 1'b1;
    end else if (req_ldr_i) begin
      gnt_o[PORT_LDR] = 1'b1;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the CPU datapath and boot loader onto one data memory port.
// DATA_MEM_ARB_ROUND_ROBIN_EN selects alternating tie-break instead of fixed ldr priority.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e              state_q, state_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                owner_q;
  logic                cpu_ack_q, ldr_ack_q;
  logic [DATA_W-1:0]   cpu_rdata_q, ldr_rdata_q;
  logic [1:0]          gnt;
  logic                last_win;
  logic                grant_now;

`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
  logic last_q;

  // Reset value "cpu won last" makes the first tie go to the loader.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'(PORT_CPU);
    end else if (grant_now) begin
      last_q <= gnt[PORT_LDR];
    end
  end
  assign last_win = last_q;
`else
  assign last_win = 1'(PORT_CPU);
`endif

  arb_pick2 u_pick (
    .req_cpu_i (cpu_req),
    .req_ldr_i (ldr_req),
    .last_i    (last_win),
    .gnt_o     (gnt)
  );

  assign grant_now = (state_q == IDLE) && (gnt != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_now) state_d = ACCESS;
      ACCESS:  state_d = we_q ? IDLE : RDWAIT;
      RDWAIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_we    = (state_q == ACCESS) && we_q;
    mem_re    = (state_q == ACCESS) && !we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
  end

  // Ack is registered so it lands in the IDLE cycle, where a held req re-arbitrates.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      owner_q     <= 1'(PORT_CPU);
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      ldr_ack_q <= 1'b0;
      if (grant_now) begin
        owner_q <= gnt[PORT_LDR];
        if (gnt[PORT_LDR]) begin
          we_q    <= ldr_we;
          addr_q  <= ldr_addr;
          wdata_q <= ldr_wdata;
        end else begin
          we_q    <= cpu_we;
          addr_q  <= cpu_addr;
          wdata_q <= cpu_wdata;
        end
      end
      if ((state_q == ACCESS && we_q) || state_q == RDWAIT) begin
        if (owner_q == 1'(PORT_LDR)) begin
          ldr_ack_q <= 1'b1;
        end else begin
          cpu_ack_q <= 1'b1;
        end
      end
      if (state_q == RDWAIT) begin
        if (owner_q == 1'(PORT_LDR)) begin
          ldr_rdata_q <= mem_rdata;
        end else begin
          cpu_rdata_q <= mem_rdata;
        end
      end
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign ldr_ack   = ldr_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;
  assign cpu_stall = cpu_req && !cpu_ack_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural memory model.
// Tie expectations follow DATA_MEM_ARB_ROUND_ROBIN_EN.
module tb_data_mem_arbiter;
  import data_mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, ldr_req, ldr_we;
  logic [7:0]  cpu_addr, ldr_addr, mem_addr;
  logic [15:0] cpu_wdata, ldr_wdata, mem_wdata, mem_rdata;
  logic        cpu_ack, ldr_ack, cpu_stall, mem_we, mem_re;
  logic [15:0] cpu_rdata, ldr_rdata;

  logic [15:0] mem [256];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .ldr_req   (ldr_req),
    .ldr_we    (ldr_we),
    .ldr_addr  (ldr_addr),
    .ldr_wdata (ldr_wdata),
    .ldr_ack   (ldr_ack),
    .ldr_rdata (ldr_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  // Memory model: synchronous write, read data one cycle after mem_re.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("t=%0t %s observed=%0h expected=%0h", $time, tag, obs, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  // Exclusivity invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("one_ack", 32'(cpu_ack & ldr_ack), 32'd0);
      check("we_re_excl", 32'(mem_we & mem_re), 32'd0);
    end
  end

  initial begin
    bit exp_ldr;
    reset = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0; mem_rdata = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
    preload(8'h05, 16'h7777);
    preload(8'h01, 16'h0101);
    preload(8'h02, 16'h0202);
    step();
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_ldr_ack", 32'(ldr_ack), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    reset = 1'b0;
    step();

    // CPU write 0x10 <= 0xBEEF
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 16'hBEEF;
    #1;
    check("wr_c0_stall", 32'(cpu_stall), 32'd1);
    step();
    check("wr_c1_mem_we", 32'(mem_we), 32'd1);
    check("wr_c1_addr", 32'(mem_addr), 32'h10);
    check("wr_c1_wdata", 32'(mem_wdata), 32'hBEEF);
    check("wr_c1_ack", 32'(cpu_ack), 32'd0);
    step();
    check("wr_c2_ack", 32'(cpu_ack), 32'd1);
    check("wr_c2_mem_we", 32'(mem_we), 32'd0);
    check("wr_c2_stall", 32'(cpu_stall), 32'd0);
    check("wr_mem10", 32'(mem[8'h10]), 32'hBEEF);
    cpu_req = 0; cpu_we = 0;
    step();

    // CPU read of preloaded 0x10 = 0x1234
    preload(8'h10, 16'h1234);
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    #1;
    check("rd_c0_stall", 32'(cpu_stall), 32'd1);
    step();
    check("rd_c1_mem_re", 32'(mem_re), 32'd1);
    check("rd_c1_stall", 32'(cpu_stall), 32'd1);
    step();
    check("rd_c2_mem_re", 32'(mem_re), 32'd0);
    check("rd_c2_ack", 32'(cpu_ack), 32'd0);
    check("rd_c2_stall", 32'(cpu_stall), 32'd1);
    step();
    check("rd_c3_ack", 32'(cpu_ack), 32'd1);
    check("rd_c3_rdata", 32'(cpu_rdata), 32'h1234);
    check("rd_c3_stall", 32'(cpu_stall), 32'd0);
    cpu_req = 0;
    step();

    // Tie: both ports write, requests held for four rounds
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h30; cpu_wdata = 16'h5555;
    ldr_req = 1; ldr_we = 1; ldr_addr = 8'h20; ldr_wdata = 16'hAAAA;
    for (int r = 0; r < 4; r++) begin
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
      exp_ldr = (r % 2 == 0);
`else
      exp_ldr = 1'b1;
`endif
      step();
      check($sformatf("tie%0d_addr", r), 32'(mem_addr), exp_ldr ? 32'h20 : 32'h30);
      check($sformatf("tie%0d_we", r), 32'(mem_we), 32'd1);
      step();
      check($sformatf("tie%0d_ldr_ack", r), 32'(ldr_ack), 32'(exp_ldr));
      check($sformatf("tie%0d_cpu_ack", r), 32'(cpu_ack), 32'(!exp_ldr));
      check($sformatf("tie%0d_stall", r), 32'(cpu_stall), 32'(exp_ldr));
    end
    cpu_req = 0; ldr_req = 0; cpu_we = 0; ldr_we = 0;
    step();

    // Reset during RDWAIT abandons the loader read
    ldr_req = 1; ldr_we = 0; ldr_addr = 8'h05;
    step();
    check("mr_c1_mem_re", 32'(mem_re), 32'd1);
    step();
    check("mr_c2_ack", 32'(ldr_ack), 32'd0);
    reset = 1; ldr_req = 0;
    step();
    check("mr_state", 32'(dut.state_q), 32'(IDLE));
    check("mr_ldr_ack", 32'(ldr_ack), 32'd0);
    check("mr_cpu_ack", 32'(cpu_ack), 32'd0);
    check("mr_mem_re", 32'(mem_re), 32'd0);
    check("mr_mem_addr", 32'(mem_addr), 32'd0);
    check("mr_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("mr_ldr_rdata", 32'(ldr_rdata), 32'd0);
    reset = 0;
    step();
    ldr_req = 1; ldr_we = 0; ldr_addr = 8'h05;
    step();
    step();
    check("fr_c2_ack", 32'(ldr_ack), 32'd0);
    step();
    check("fr_c3_ack", 32'(ldr_ack), 32'd1);
    check("fr_c3_rdata", 32'(ldr_rdata), 32'h7777);
    ldr_req = 0;
    step();

    // Back-to-back loader reads, req held across the first ack
    ldr_req = 1; ldr_we = 0; ldr_addr = 8'h01;
    step();
    step();
    step();
    check("b2b_a1_ack", 32'(ldr_ack), 32'd1);
    check("b2b_a1_rdata", 32'(ldr_rdata), 32'h0101);
    check("b2b_a1_cpu_ack", 32'(cpu_ack), 32'd0);
    ldr_addr = 8'h02;
    step();
    check("b2b_c4_mem_re", 32'(mem_re), 32'd1);
    check("b2b_c4_ack", 32'(ldr_ack), 32'd0);
    step();
    check("b2b_c5_ack", 32'(ldr_ack), 32'd0);
    step();
    check("b2b_a2_ack", 32'(ldr_ack), 32'd1);
    check("b2b_a2_rdata", 32'(ldr_rdata), 32'h0202);
    check("b2b_a2_cpu_ack", 32'(cpu_ack), 32'd0);
    ldr_req = 0;
    step();
    check("hold_ldr_rdata", 32'(ldr_rdata), 32'h0202);
    check("hold_ldr_ack", 32'(ldr_ack), 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_W, 8, data memory address width.
- DATA_W, 16, data word width.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on posedge.
- reset, in, 1, synchronous active-high reset.
- cpu_req / ldr_req, in, 1, access request from control-unit datapath (port 0) or boot loader (port 1).
- cpu_we / ldr_we, in, 1, 1 = write, 0 = read.
- cpu_addr / ldr_addr, in, ADDR_W, access address.
- cpu_wdata / ldr_wdata, in, DATA_W, write data.
- cpu_ack / ldr_ack, out, 1, one-cycle completion pulse.
- cpu_rdata / ldr_rdata, out, DATA_W, read data; valid while the matching ack is high.
- cpu_stall, out, 1, high while cpu_req is pending and not acked; gates micro-PC advance.
- mem_addr, out, ADDR_W, memory address.
- mem_wdata, out, DATA_W, memory write data.
- mem_we / mem_re, out, 1, memory write / read strobes.
- mem_rdata, in, DATA_W, memory read data; valid one cycle after mem_re.
REQ-003 The clock port SHALL be clk and the reset port reset; one clock; reset is synchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, ACCESS, RDWAIT.
REQ-005 In IDLE with any req high, the arbiter SHALL select a winner, latch its we/addr/wdata, and enter ACCESS at the next edge.
REQ-006 In ACCESS, mem_addr/mem_wdata SHALL carry the latched values, with exactly one of mem_we/mem_re high for one cycle.
REQ-007 A write SHALL return ACCESS->IDLE and pulse the winner's ack in the cycle after ACCESS (latency: req seen in IDLE to ack = 2 cycles).
REQ-008 A read SHALL go ACCESS->RDWAIT, register mem_rdata into the winner's rdata, and pulse ack on RDWAIT->IDLE (latency 3 cycles).
REQ-009 Requests sampled outside IDLE SHALL be ignored; a requester SHALL hold req and its operands stable until ack.
REQ-010 A req still high in the ack cycle SHALL be treated as a new request; back-to-back accesses SHALL therefore have no idle gap.
REQ-011 Simultaneous requests SHALL follow the policy in REQ-016.
REQ-012 cpu_stall SHALL equal cpu_req AND NOT cpu_ack (combinational).
REQ-013 rdata outputs SHALL hold their last value until the next read completes on that port.
REQ-014 Only one ack SHALL be high in any cycle; mem_we and mem_re SHALL never both be high.

Reset
REQ-015 While reset is high: state = IDLE; all acks, mem_we and mem_re = 0; mem_addr, mem_wdata and both rdata = 0; the round-robin pointer favours ldr. An access in flight SHALL be abandoned with no ack.

Configuration
REQ-016 Macro DATA_MEM_ARB_ROUND_ROBIN_EN:
- Defined: on a tie, the port that did not win the last grant SHALL win; the pointer updates only on a grant.
- Undefined: fixed priority, ldr always wins a tie; the pointer logic is absent.

Structure
REQ-017 A shared package SHALL hold the state enum (IDLE/ACCESS/RDWAIT), port index constants (PORT_CPU = 0, PORT_LDR = 1) and the ADDR_W/DATA_W defaults.
REQ-018 The winner selection SHALL be a sub-module arb_pick2 (two req inputs, last-winner input, one-hot grant output); the FSM and datapath stay in data_mem_arbiter.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- CPU write: cpu_req, we=1, addr 0x10, wdata 0xBEEF -> mem_we high 1 cycle with addr 0x10 and data 0xBEEF; cpu_ack 2 cycles after the request; memory location 0x10 = 0xBEEF.
- CPU read: preload 0x10 = 0x1234, cpu_req, we=0 -> mem_re 1 cycle; cpu_ack at +3 cycles with cpu_rdata = 0x1234; cpu_stall high for cycles 0-2 and low at ack.
- Tie, 4 back-to-back rounds with both reqs held: with the macro, grants alternate ldr, cpu, ldr, cpu; without it, ldr wins all four and cpu_stall stays high.
- Mid-operation reset: reset asserted during RDWAIT -> no ack; the next cycle shows state IDLE and all outputs 0; a fresh request completes normally.
- Back-to-back reads: ldr_req held for 2 reads at addr 0x01 then 0x02 -> two acks exactly 3 cycles apart, each with correct data; no cpu_ack is ever coincident.
